// File: rtl/rd_pkg.sv
// Shared definitions for the multi-agent reward decider: table-select codes,
// default widths, and the width rule used by the saturating accumulator.
// No logic or state; imported by rd_lane and reward_decider_ma.
package rd_pkg;

  // Reward-table entry codes carried on cfg_sel; code 3 selects no entry.
  typedef enum logic [1:0] {
    SEL_R0   = 2'd0,
    SEL_R1   = 2'd1,
    SEL_R2   = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  localparam int DEF_N_AGENT = 4;
  localparam int DEF_A_W     = 2;
  localparam int DEF_R_W     = 32;
  localparam int DEF_ACC_W   = 40;

  // The saturating add runs one bit wider than the accumulator so that
  // signed overflow shows up as a mismatch between the top two sum bits.
  function automatic int sat_sum_w(input int acc_w);
    return acc_w + 1;
  endfunction

endpackage

// File: rtl/rd_lane.sv
// One agent lane: stage-1 action registers, reward select, r_out register, saturating accumulator.
// Latency: two register stages from input to r_out; acc_out follows one cycle after an output transfer.
// Backpressure: all pipeline registers hold while en is low; the accumulator moves only on xfer.
module rd_lane
  import rd_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int R_W   = DEF_R_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s1_valid,
  input  logic             xfer,
  input  logic             ep_clr,
  input  logic [A_W-1:0]   amax,
  input  logic [A_W-1:0]   amin,
  input  logic [A_W-1:0]   act,
  input  logic [R_W-1:0]   r0,
  input  logic [R_W-1:0]   r1,
  input  logic [R_W-1:0]   r2,
  output logic [R_W-1:0]   r_out,
  output logic [ACC_W-1:0] acc_out
);

  localparam int SUM_W = sat_sum_w(ACC_W);

  logic [A_W-1:0]          amax_q;
  logic [A_W-1:0]          amin_q;
  logic [A_W-1:0]          act_q;
  logic [R_W-1:0]          sel_r;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] r_ext;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_sat;

  // Stage 1: capture all three action indices together so they stay aligned to one beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amax_q <= '0;
      amin_q <= '0;
      act_q  <= '0;
    end else if (en) begin
      amax_q <= amax;
      amin_q <= amin;
      act_q  <= act;
    end
  end

  // Select: a greedy match wins even when the worst action is the same index.
  always_comb begin
    sel_r = r1;
    if (act_q == amax_q) begin
      sel_r = r2;
    end else if (act_q == amin_q) begin
      sel_r = r0;
    end
  end

  // Stage 2: latch the selected reward with whatever table value is live this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (en && s1_valid) begin
      r_out <= sel_r;
    end
  end

  assign r_ext = ACC_W'($signed(r_out));
  assign sum   = SUM_W'(acc_q) + SUM_W'(r_ext);

  // Clamp to the signed accumulator range instead of wrapping.
  always_comb begin
    acc_sat = sum[ACC_W-1:0];
    if (sum[SUM_W-1] != sum[SUM_W-2]) begin
      acc_sat = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Accumulator: an episode clear that meets a transfer starts the new episode with that beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (ep_clr && xfer) begin
      acc_q <= r_ext;
    end else if (ep_clr) begin
      acc_q <= '0;
    end else if (xfer) begin
      acc_q <= acc_sat;
    end
  end

  assign acc_out = acc_q;

endmodule

// File: rtl/reward_decider_ma.sv
// Multi-agent reward decider: per-lane reward lookup from a shared 3-entry table plus episode accumulators.
// Latency: two cycles from input acceptance to out_valid when unstalled; 1 beat/cycle throughput.
// Backpressure: in_ready = ~out_valid | out_ready; the whole pipeline holds while it is low.
module reward_decider_ma
  import rd_pkg::*;
#(
  parameter int                    N_AGENT = DEF_N_AGENT,
  parameter int                    A_W     = DEF_A_W,
  parameter int                    R_W     = DEF_R_W,
  parameter int                    ACC_W   = DEF_ACC_W,
  parameter logic signed [R_W-1:0] R0_INIT = R_W'(-1),
  parameter logic signed [R_W-1:0] R1_INIT = R_W'(0),
  parameter logic signed [R_W-1:0] R2_INIT = R_W'(1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_sel,
  input  logic [R_W-1:0]           cfg_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_AGENT*A_W-1:0]   amax,
  input  logic [N_AGENT*A_W-1:0]   amin,
  input  logic [N_AGENT*A_W-1:0]   act,
  input  logic                     ep_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_AGENT*R_W-1:0]   r_out,
  output logic [N_AGENT*ACC_W-1:0] acc_out
);

  logic           en;
  logic           xfer;
  logic           s1_valid;
  logic [R_W-1:0] tbl_r0;
  logic [R_W-1:0] tbl_r1;
  logic [R_W-1:0] tbl_r2;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign xfer     = out_valid & out_ready;

  // Reward table: a write lands at the edge, so a select in the same cycle sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_r0 <= R0_INIT;
      tbl_r1 <= R1_INIT;
      tbl_r2 <= R2_INIT;
    end else if (cfg_we) begin
      case (sel_e'(cfg_sel))
        SEL_R0:  tbl_r0 <= cfg_data;
        SEL_R1:  tbl_r1 <= cfg_data;
        SEL_R2:  tbl_r2 <= cfg_data;
        default: ;
      endcase
    end
  end

  // Valid pipeline shared by all lanes; advances only when the output side can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  for (genvar i = 0; i < N_AGENT; i++) begin : g_lane
    rd_lane #(
      .A_W   (A_W),
      .R_W   (R_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .s1_valid (s1_valid),
      .xfer     (xfer),
      .ep_clr   (ep_clr),
      .amax     (amax[i*A_W +: A_W]),
      .amin     (amin[i*A_W +: A_W]),
      .act      (act[i*A_W +: A_W]),
      .r0       (tbl_r0),
      .r1       (tbl_r1),
      .r2       (tbl_r2),
      .r_out    (r_out[i*R_W +: R_W]),
      .acc_out  (acc_out[i*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_reward_decider_ma.sv
// Directed bench for reward_decider_ma: default 4-lane instance plus a narrow
// 1-lane instance (R_W = ACC_W = 8, R2 = +100) for accumulator saturation.
module tb_reward_decider_ma;

  logic         clk = 1'b0;
  logic         rst;

  logic         cfg_we, in_valid, in_ready, ep_clr, out_valid, out_ready;
  logic [1:0]   cfg_sel;
  logic [31:0]  cfg_data;
  logic [7:0]   amax, amin, act;
  logic [127:0] r_out;
  logic [159:0] acc_out;

  logic         s_cfg_we, s_in_valid, s_in_ready, s_ep_clr, s_out_valid, s_out_ready;
  logic [1:0]   s_cfg_sel;
  logic [7:0]   s_cfg_data;
  logic [1:0]   s_amax, s_amin, s_act;
  logic [7:0]   s_r_out;
  logic [7:0]   s_acc_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] pat [8] = '{8'hAA, 8'h00, 8'h55, 8'hFF, 8'h1B, 8'hE4, 8'h27, 8'h9C};

  always #5 clk = ~clk;

  reward_decider_ma u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .amax(amax), .amin(amin), .act(act),
    .ep_clr(ep_clr), .out_valid(out_valid), .out_ready(out_ready),
    .r_out(r_out), .acc_out(acc_out)
  );

  reward_decider_ma #(
    .N_AGENT(1), .A_W(2), .R_W(8), .ACC_W(8),
    .R0_INIT(8'hFF), .R1_INIT(8'h00), .R2_INIT(8'd100)
  ) u_sat (
    .clk(clk), .rst(rst), .cfg_we(s_cfg_we), .cfg_sel(s_cfg_sel), .cfg_data(s_cfg_data),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .amax(s_amax), .amin(s_amin), .act(s_act),
    .ep_clr(s_ep_clr), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .r_out(s_r_out), .acc_out(s_acc_out)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected 4-lane reward word: greedy match first, then worst match, else middle entry.
  function automatic logic [127:0] exp_r(input logic [7:0] amx, input logic [7:0] amn,
                                         input logic [7:0] ac, input logic [31:0] r0,
                                         input logic [31:0] r1, input logic [31:0] r2);
    logic [127:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      if (ac[i*2 +: 2] == amx[i*2 +: 2])      res[i*32 +: 32] = r2;
      else if (ac[i*2 +: 2] == amn[i*2 +: 2]) res[i*32 +: 32] = r0;
      else                                    res[i*32 +: 32] = r1;
    end
    return res;
  endfunction

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = '0; in_valid = 1'b0; ep_clr = 1'b0; out_ready = 1'b1;
    amax = '0; amin = '0; act = '0;
    s_cfg_we = 1'b0; s_cfg_sel = 2'd0; s_cfg_data = '0; s_in_valid = 1'b0; s_ep_clr = 1'b0;
    s_out_ready = 1'b1; s_amax = '0; s_amin = '0; s_act = '0;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_r_out", r_out, 0);
    check("rst_acc", acc_out, 0);
    tick;
    rst = 1'b0;
    tick;

    // Mixed lanes: +1, -1, 0, and the all-equal case picking R2
    amax = 8'hEA; amin = 8'hC0; act = 8'hD2; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("lat_not_yet", out_valid, 0);
    tick;
    check("mix_valid", out_valid, 1);
    check("mix_r_out", r_out, {32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1});
    tick;
    check("mix_drain", out_valid, 0);
    check("mix_acc", acc_out, {40'd1, 40'd0, {40{1'b1}}, 40'd1});

    // Episode clear without a transfer
    ep_clr = 1'b1;
    tick;
    ep_clr = 1'b0;
    check("clr_acc", acc_out, 0);

    // Back-to-back stream of 8 beats
    amax = 8'hAA; amin = 8'h00;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      if (c < 8) act = pat[c];
      tick;
      if (c >= 1 && c <= 8) begin
        check("stream_valid", out_valid, 1);
        check("stream_r_out", r_out, exp_r(8'hAA, 8'h00, pat[c-1], 32'hFFFF_FFFF, 32'd0, 32'd1));
      end else if (c == 9) begin
        check("stream_end", out_valid, 0);
      end
    end
    in_valid = 1'b0;

    // Stall: three beats offered with out_ready low
    out_ready = 1'b0;
    act = 8'hAA; in_valid = 1'b1;
    check("stall_rdy_first", in_ready, 1);
    tick;
    act = 8'h00;
    tick;
    check("stall_rdy_drop", in_ready, 0);
    check("stall_valid", out_valid, 1);
    act = 8'h55;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("stall_hold_r", r_out, {4{32'd1}});
      check("stall_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    check("release_b_v", out_valid, 1);
    check("release_b_r", r_out, {4{32'hFFFF_FFFF}});
    tick;
    check("release_c_v", out_valid, 1);
    check("release_c_r", r_out, 128'd0);
    tick;
    check("release_end", out_valid, 0);

    // Table write to R2, then an ignored write with cfg_sel=3
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 32'd100;
    tick;
    cfg_we = 1'b0;
    act = 8'hAA; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    check("cfg_r2", r_out, {4{32'd100}});
    tick;
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 32'd7;
    tick;
    cfg_we = 1'b0;
    act = 8'h18; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    check("cfg_sel3", r_out, {32'hFFFF_FFFF, 32'd0, 32'd100, 32'hFFFF_FFFF});
    tick;

    // A write in the select cycle is not visible to that beat
    act = 8'h00; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'd5;
    tick;
    cfg_we = 1'b0;
    check("wr_same_cycle", r_out, {4{32'hFFFF_FFFF}});
    tick;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    check("wr_next_beat", r_out, {4{32'd5}});
    tick;

    // Asynchronous reset with two beats in flight
    act = 8'hAA; in_valid = 1'b1;
    tick;
    act = 8'h55;
    tick;
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_r_out", r_out, 0);
    check("arst_acc", acc_out, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("post_rst_idle", out_valid, 0);
    end
    act = 8'hAA; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    check("table_reinit", r_out, {4{32'd1}});
    tick;

    // Narrow instance: positive saturation, then ep_clr with a -1 transfer
    s_amax = 2'd2; s_amin = 2'd0; s_act = 2'd2; s_in_valid = 1'b1;
    tick;
    tick;
    s_in_valid = 1'b0;
    tick;
    check("sat_acc_first", s_acc_out, 8'd100);
    tick;
    check("sat_acc_clamp", s_acc_out, 8'h7F);
    check("sat_drain", s_out_valid, 0);
    s_act = 2'd0; s_in_valid = 1'b1;
    tick;
    s_in_valid = 1'b0;
    tick;
    check("sat_r_neg", s_r_out, 8'hFF);
    s_ep_clr = 1'b1;
    tick;
    s_ep_clr = 1'b0;
    check("sat_clr_xfer", s_acc_out, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
